// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock time-setting sequencer: FSM encodings,
// field highlight codes, BCD bounds and digit constants.
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;
  localparam logic [1:0] FIELD_SEC  = 2'b11;

  localparam logic [7:0] HOUR_MAX_DEF   = 8'h23;
  localparam logic [7:0] MINSEC_MAX_DEF = 8'h59;
  localparam logic [7:0] BCD_ZERO       = 8'h00;
  localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
  localparam logic [3:0] BCD_DIGIT_MIN  = 4'd0;

endpackage

// File: rtl/clock_set_ctrl_bcd_step.sv
// Combinational two-digit BCD +/-1 with wrap between 00 and max.
// up and dn together (or neither) leave the value unchanged.
module clock_set_ctrl_bcd_step
  import clock_set_ctrl_pkg::*;
(
  input  logic [7:0] val,
  input  logic [7:0] max,
  input  logic       up,
  input  logic       dn,
  output logic [7:0] nxt
);

  always_comb begin
    nxt = val;
    if (up && !dn) begin
      if (val == max)
        nxt = BCD_ZERO;
      else if (val[3:0] == BCD_DIGIT_MAX)
        nxt = {val[7:4] + 4'd1, BCD_DIGIT_MIN};
      else
        nxt = {val[7:4], val[3:0] + 4'd1};
    end else if (dn && !up) begin
      if (val == BCD_ZERO)
        nxt = max;
      else if (val[3:0] == BCD_DIGIT_MIN)
        nxt = {val[7:4] - 4'd1, BCD_DIGIT_MAX};
      else
        nxt = {val[7:4], val[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting sequencer: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN, editing a BCD
// shadow and writing it back via load strobes. Define BLINK_EN to build the blink divider.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter logic [7:0]  HOUR_MAX    = HOUR_MAX_DEF,
  parameter logic [7:0]  MINSEC_MAX  = MINSEC_MAX_DEF,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1000
`ifdef BLINK_EN
  ,
  parameter logic [15:0] BLINK_DIV   = 16'd50
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic [7:0] hour_in,
  input  logic [7:0] min_in,
  input  logic [7:0] sec_in,
  output logic       cnt_en,
  output logic       load_hour,
  output logic       load_min,
  output logic       load_sec,
  output logic [7:0] set_data,
  output logic [1:0] field_sel,
  output logic       blink,
  output state_e     dbg_state_o
);

  state_e      state_q, state_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [31:0] idle_q, idle_d;
  logic        cnt_en_q, cnt_en_d;
  logic        load_hour_q, load_hour_d;
  logic        load_min_q, load_min_d;
  logic        load_sec_q, load_sec_d;
  logic [7:0]  set_data_q, set_data_d;
  logic [1:0]  field_sel_q, field_sel_d;
  logic [7:0]  step_max, step_nxt;
  logic        any_key, timeout;

  assign any_key  = key_mode | key_inc | key_dec;
  assign timeout  = !any_key && (idle_q == TIMEOUT_CYC - 32'd1);
  assign step_max = (state_q == ST_SET_HOUR) ? HOUR_MAX : MINSEC_MAX;

  clock_set_ctrl_bcd_step u_step (
    .val (shadow_q),
    .max (step_max),
    .up  (key_inc),
    .dn  (key_dec),
    .nxt (step_nxt)
  );

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    idle_d      = idle_q;
    cnt_en_d    = cnt_en_q;
    load_hour_d = 1'b0;
    load_min_d  = 1'b0;
    load_sec_d  = 1'b0;
    set_data_d  = set_data_q;
    field_sel_d = field_sel_q;
    if (state_q == ST_RUN) begin
      if (key_mode) begin
        state_d     = ST_SET_HOUR;
        shadow_d    = hour_in;
        cnt_en_d    = 1'b0;
        field_sel_d = FIELD_HOUR;
        idle_d      = '0;
      end
    end else if (key_mode || timeout) begin
      // Commit the field being edited; key_mode drops any simultaneous inc/dec.
      set_data_d = shadow_q;
      idle_d     = '0;
      case (state_q)
        ST_SET_HOUR: load_hour_d = 1'b1;
        ST_SET_MIN:  load_min_d  = 1'b1;
        default:     load_sec_d  = 1'b1;
      endcase
      if (key_mode && state_q == ST_SET_HOUR) begin
        state_d     = ST_SET_MIN;
        shadow_d    = min_in;
        field_sel_d = FIELD_MIN;
      end else if (key_mode && state_q == ST_SET_MIN) begin
        state_d     = ST_SET_SEC;
        shadow_d    = sec_in;
        field_sel_d = FIELD_SEC;
      end else begin
        state_d     = ST_RUN;
        cnt_en_d    = 1'b1;
        field_sel_d = FIELD_NONE;
      end
    end else if (key_inc || key_dec) begin
      shadow_d = step_nxt;
      idle_d   = '0;
    end else begin
      idle_d = idle_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      shadow_q    <= BCD_ZERO;
      idle_q      <= '0;
      cnt_en_q    <= 1'b1;
      load_hour_q <= 1'b0;
      load_min_q  <= 1'b0;
      load_sec_q  <= 1'b0;
      set_data_q  <= BCD_ZERO;
      field_sel_q <= FIELD_NONE;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      idle_q      <= idle_d;
      cnt_en_q    <= cnt_en_d;
      load_hour_q <= load_hour_d;
      load_min_q  <= load_min_d;
      load_sec_q  <= load_sec_d;
      set_data_q  <= set_data_d;
      field_sel_q <= field_sel_d;
    end
  end

`ifdef BLINK_EN
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_q, blink_d;

  // Restart the phase on any field change or key so the edited digit is shown at once.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (state_d == ST_RUN || state_d != state_q || any_key) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BLINK_DIV - 16'd1) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b1;
`endif

  assign cnt_en      = cnt_en_q;
  assign load_hour   = load_hour_q;
  assign load_min    = load_min_q;
  assign load_sec    = load_sec_q;
  assign set_data    = set_data_q;
  assign field_sel   = field_sel_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed key sequences, load strobes checked by a
// scoreboard queue of {field, data}; state/enable outputs checked inline.
module tb_clock_set_ctrl;
  import clock_set_ctrl_pkg::*;

  logic       clk, rst_n;
  logic       key_mode, key_inc, key_dec;
  logic [7:0] hour_in, min_in, sec_in;
  logic       cnt_en, load_hour, load_min, load_sec, blink;
  logic [7:0] set_data;
  logic [1:0] field_sel;
  state_e     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];

  clock_set_ctrl #(
    .TIMEOUT_CYC (32'd16)
`ifdef BLINK_EN
    ,
    .BLINK_DIV   (16'd4)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_mode    (key_mode),
    .key_inc     (key_inc),
    .key_dec     (key_dec),
    .hour_in     (hour_in),
    .min_in      (min_in),
    .sec_in      (sec_in),
    .cnt_en      (cnt_en),
    .load_hour   (load_hour),
    .load_min    (load_min),
    .load_sec    (load_sec),
    .set_data    (set_data),
    .field_sel   (field_sel),
    .blink       (blink),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    key_mode = m;
    key_inc  = i;
    key_dec  = d;
    @(posedge clk);
    #1;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    key_dec  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_load(input logic [1:0] f, input logic [7:0] d);
    exp_q.push_back({f, d});
  endtask

  task automatic set_inputs(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    hour_in = h;
    min_in  = m;
    sec_in  = s;
  endtask

  // Monitor: every cycle with a load strobe must match the head of the queue.
  always @(negedge clk) begin
    logic [1:0] f;
    logic [9:0] e;
    if (rst_n && (load_hour || load_min || load_sec)) begin
      case ({load_hour, load_min, load_sec})
        3'b100:  f = FIELD_HOUR;
        3'b010:  f = FIELD_MIN;
        3'b001:  f = FIELD_SEC;
        default: f = FIELD_NONE;
      endcase
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_load: got field %0d data %0h, none expected at %0t", f, set_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("load_field_data", {22'd0, f, set_data}, {22'd0, e});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    key_dec  = 1'b0;
    set_inputs(8'h12, 8'h34, 8'h56);
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt_en", cnt_en, 1);
    check("rst_field_sel", field_sel, FIELD_NONE);
    check("rst_set_data", set_data, 8'h00);
    check("rst_blink", blink, 1);
    check("rst_state", dbg_state, ST_RUN);
    rst_n = 1'b1;

    // Idle in RUN
    idle(20);
    check("idle_cnt_en", cnt_en, 1);
    check("idle_field_sel", field_sel, FIELD_NONE);

    // Edit hour 12 -> 15, min 34 unchanged, sec 56 -> 00 through 59
    press(1, 0, 0);
    check("enter_field_sel", field_sel, FIELD_HOUR);
    check("enter_cnt_en", cnt_en, 0);
    check("enter_state", dbg_state, ST_SET_HOUR);
    repeat (3) press(0, 1, 0);
    expect_load(FIELD_HOUR, 8'h15);
    press(1, 0, 0);
    check("to_min_field_sel", field_sel, FIELD_MIN);
    check("to_min_cnt_en", cnt_en, 0);
    expect_load(FIELD_MIN, 8'h34);
    press(1, 0, 0);
    check("to_sec_field_sel", field_sel, FIELD_SEC);
    repeat (4) press(0, 1, 0);
    expect_load(FIELD_SEC, 8'h00);
    press(1, 0, 0);
    check("exit_field_sel", field_sel, FIELD_NONE);
    check("exit_cnt_en", cnt_en, 1);

    // Wrap cases: hour 23 inc -> 00, min 09 inc -> 10, sec 56 dec -> 55
    set_inputs(8'h23, 8'h09, 8'h56);
    press(0, 1, 0);
    check("run_ignores_inc", field_sel, FIELD_NONE);
    press(1, 0, 0);
    press(0, 1, 0);
    expect_load(FIELD_HOUR, 8'h00);
    press(1, 0, 0);
    press(0, 1, 0);
    expect_load(FIELD_MIN, 8'h10);
    press(1, 0, 0);
    press(0, 0, 1);
    expect_load(FIELD_SEC, 8'h55);
    press(1, 0, 0);

    // hour 23 inc,dec -> 23; min 59 inc -> 00; sec 00 dec -> 59
    set_inputs(8'h23, 8'h59, 8'h00);
    press(1, 0, 0);
    press(0, 1, 0);
    press(0, 0, 1);
    expect_load(FIELD_HOUR, 8'h23);
    press(1, 0, 0);
    press(0, 1, 0);
    expect_load(FIELD_MIN, 8'h00);
    press(1, 0, 0);
    press(0, 0, 1);
    expect_load(FIELD_SEC, 8'h59);
    press(1, 0, 0);

    // hour 19 inc -> 20; min 10 dec -> 09; sec 40 dec -> 39
    set_inputs(8'h19, 8'h10, 8'h40);
    press(1, 0, 0);
    press(0, 1, 0);
    expect_load(FIELD_HOUR, 8'h20);
    press(1, 0, 0);
    press(0, 0, 1);
    expect_load(FIELD_MIN, 8'h09);
    press(1, 0, 0);
    press(0, 0, 1);
    expect_load(FIELD_SEC, 8'h39);
    press(1, 0, 0);

    // hour 00 dec -> 23; min 00 dec -> 59; sec inc+dec together -> unchanged
    set_inputs(8'h00, 8'h00, 8'h20);
    press(1, 0, 0);
    press(0, 0, 1);
    expect_load(FIELD_HOUR, 8'h23);
    press(1, 0, 0);
    press(0, 0, 1);
    expect_load(FIELD_MIN, 8'h59);
    press(1, 0, 0);
    press(0, 1, 1);
    expect_load(FIELD_SEC, 8'h20);
    press(1, 0, 0);

    // Plain four-mode walk
    set_inputs(8'h07, 8'h08, 8'h09);
    press(1, 0, 0);
    expect_load(FIELD_HOUR, 8'h07);
    press(1, 0, 0);
    check("walk_cnt_en_min", cnt_en, 0);
    expect_load(FIELD_MIN, 8'h08);
    press(1, 0, 0);
    check("walk_cnt_en_sec", cnt_en, 0);
    expect_load(FIELD_SEC, 8'h09);
    press(1, 0, 0);
    check("walk_cnt_en_run", cnt_en, 1);

    // key_mode wins over key_inc in SET_MIN
    set_inputs(8'h11, 8'h30, 8'h45);
    press(1, 0, 0);
    expect_load(FIELD_HOUR, 8'h11);
    press(1, 0, 0);
    expect_load(FIELD_MIN, 8'h30);
    press(1, 1, 0);
    check("mode_inc_field_sel", field_sel, FIELD_SEC);
    expect_load(FIELD_SEC, 8'h45);
    press(1, 0, 0);

    // Timeout in SET_HOUR after 16 idle cycles
    set_inputs(8'h08, 8'h21, 8'h33);
    press(1, 0, 0);
    idle(15);
    check("pre_timeout_field_sel", field_sel, FIELD_HOUR);
    check("pre_timeout_cnt_en", cnt_en, 0);
    expect_load(FIELD_HOUR, 8'h08);
    idle(1);
    check("timeout_field_sel", field_sel, FIELD_NONE);
    check("timeout_cnt_en", cnt_en, 1);
    check("timeout_state", dbg_state, ST_RUN);

    // Key in SET_MIN restarts the idle count; later sec field untouched
    press(1, 0, 0);
    expect_load(FIELD_HOUR, 8'h08);
    press(1, 0, 0);
    idle(10);
    press(0, 1, 0);
    idle(15);
    check("idle_restart_field_sel", field_sel, FIELD_MIN);
    expect_load(FIELD_MIN, 8'h22);
    idle(1);
    check("min_timeout_field_sel", field_sel, FIELD_NONE);
    check("min_timeout_cnt_en", cnt_en, 1);
    idle(5);

    // Async reset mid SET_MIN discards the edit with no load
    set_inputs(8'h05, 8'h44, 8'h33);
    press(1, 0, 0);
    expect_load(FIELD_HOUR, 8'h05);
    press(1, 0, 0);
    press(0, 1, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt_en", cnt_en, 1);
    check("async_rst_field_sel", field_sel, FIELD_NONE);
    check("async_rst_state", dbg_state, ST_RUN);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("post_rst_field_sel", field_sel, FIELD_NONE);
    press(1, 0, 0);
    expect_load(FIELD_HOUR, 8'h05);
    press(1, 0, 0);
    expect_load(FIELD_MIN, 8'h44);
    press(1, 0, 0);
    expect_load(FIELD_SEC, 8'h33);
    press(1, 0, 0);

    // Blink phase
    set_inputs(8'h14, 8'h15, 8'h16);
    idle(6);
    check("run_blink", blink, 1);
    press(1, 0, 0);
`ifdef BLINK_EN
    idle(3);
    check("blink_hold", blink, 1);
    idle(1);
    check("blink_toggle_low", blink, 0);
    idle(3);
    check("blink_stay_low", blink, 0);
    idle(1);
    check("blink_toggle_high", blink, 1);
    idle(3);
    check("blink_pre_key", blink, 1);
    idle(1);
    check("blink_low_again", blink, 0);
    press(0, 1, 0);
    check("blink_key_restart", blink, 1);
`else
    idle(6);
    check("blink_tied_set", blink, 1);
    press(0, 1, 0);
`endif
    expect_load(FIELD_HOUR, 8'h15);
    press(1, 0, 0);
    expect_load(FIELD_MIN, 8'h15);
    press(1, 0, 0);
    expect_load(FIELD_SEC, 8'h16);
    press(1, 0, 0);
    check("final_blink", blink, 1);

    idle(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
